// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/arith/branch ops plus iterative shift-add
// multiply and restoring divide. Define ULA_OVERFLOW_EN to add the overflow output.
module ula_multiciclo #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       sinal_controle,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] resultado,
    output logic [WIDTH-1:0] resultado_hi,
    output logic             zero,
    output logic             condicao,
    output logic             erro,
`ifdef ULA_OVERFLOW_EN
    output logic             overflow,
`endif
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] oper_q, oper_d;
    logic [WIDTH-1:0] work_hi_q, work_hi_d;
    logic [WIDTH-1:0] work_lo_q, work_lo_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zero_q, zero_d;
    logic             cond_q, cond_d;
    logic             erro_q, erro_d;
    logic             done_q, done_d;
`ifdef ULA_OVERFLOW_EN
    logic             ovf_q, ovf_d;
    logic             ovf_c;
`endif

    logic [WIDTH-1:0] sum_c, diff_c, alu_c;
    logic             cond_c, err_c;

    // Single-cycle result path
    always_comb begin
        sum_c  = a + b;
        diff_c = a - b;
        alu_c  = '0;
        cond_c = 1'b0;
        err_c  = 1'b0;
        case (sinal_controle)
            4'd0:  alu_c = a & b;
            4'd1:  alu_c = a | b;
            4'd2:  alu_c = sum_c;
            4'd3:  alu_c = diff_c;
            4'd6:  alu_c = b >> shamt;
            4'd7:  alu_c = b << shamt;
            4'd8:  alu_c = ~(a | b);
            4'd9:  begin alu_c = diff_c; cond_c = (a == b); end
            4'd10: begin alu_c = diff_c; cond_c = ($signed(a) < $signed(b)); end
            4'd11: begin alu_c = diff_c; cond_c = ($signed(a) > $signed(b)); end
            4'd12: begin alu_c = diff_c; cond_c = (a != b); end
            4'd13: alu_c = a;
            default: err_c = 1'b1;
        endcase
`ifdef ULA_OVERFLOW_EN
        ovf_c = 1'b0;
        if (sinal_controle == 4'd2)
            ovf_c = (a[WIDTH-1] == b[WIDTH-1]) && (sum_c[WIDTH-1] != a[WIDTH-1]);
        else if (sinal_controle == 4'd3)
            ovf_c = (a[WIDTH-1] != b[WIDTH-1]) && (diff_c[WIDTH-1] != a[WIDTH-1]);
`endif
    end

    // One iteration step each for multiply ({hi,lo} shifts right) and divide
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n, div_hi_n, div_lo_n;

    always_comb begin
        mul_sum   = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, oper_q} : '0);
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], work_lo_q[WIDTH-1:1]};
        div_shift = {work_hi_q, work_lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, oper_q};
        // Borrow out of the trial subtraction means restore the shifted remainder
        div_hi_n  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
        div_lo_n  = {work_lo_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        oper_d    = oper_q;
        work_hi_d = work_hi_q;
        work_lo_d = work_lo_q;
        res_d     = res_q;
        res_hi_d  = res_hi_q;
        zero_d    = zero_q;
        cond_d    = cond_q;
        erro_d    = erro_q;
        done_d    = 1'b0;
`ifdef ULA_OVERFLOW_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d   = '0;
                    work_hi_d = '0;
                    if (sinal_controle == 4'd4) begin
                        oper_d    = a;
                        work_lo_d = b;
                        state_d   = MUL;
                    end else if (sinal_controle == 4'd5 && b != '0) begin
                        oper_d    = b;
                        work_lo_d = a;
                        state_d   = DIV;
                    end else if (sinal_controle == 4'd5) begin
                        res_d    = '1;
                        res_hi_d = a;
                        zero_d   = 1'b0;
                        cond_d   = 1'b0;
                        erro_d   = 1'b1;
                        done_d   = 1'b1;
`ifdef ULA_OVERFLOW_EN
                        ovf_d    = 1'b0;
`endif
                    end else begin
                        res_d    = alu_c;
                        res_hi_d = '0;
                        zero_d   = (alu_c == '0);
                        cond_d   = cond_c;
                        erro_d   = err_c;
                        done_d   = 1'b1;
`ifdef ULA_OVERFLOW_EN
                        ovf_d    = ovf_c;
`endif
                    end
                end
            end
            MUL, DIV: begin
                count_d   = count_q + 1'b1;
                work_hi_d = (state_q == MUL) ? mul_hi_n : div_hi_n;
                work_lo_d = (state_q == MUL) ? mul_lo_n : div_lo_n;
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d  = IDLE;
                    res_d    = work_lo_d;
                    res_hi_d = work_hi_d;
                    zero_d   = (work_lo_d == '0);
                    cond_d   = 1'b0;
                    erro_d   = 1'b0;
                    done_d   = 1'b1;
`ifdef ULA_OVERFLOW_EN
                    ovf_d    = 1'b0;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            oper_q    <= '0;
            work_hi_q <= '0;
            work_lo_q <= '0;
            res_q     <= '0;
            res_hi_q  <= '0;
            zero_q    <= 1'b0;
            cond_q    <= 1'b0;
            erro_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef ULA_OVERFLOW_EN
            ovf_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            oper_q    <= oper_d;
            work_hi_q <= work_hi_d;
            work_lo_q <= work_lo_d;
            res_q     <= res_d;
            res_hi_q  <= res_hi_d;
            zero_q    <= zero_d;
            cond_q    <= cond_d;
            erro_q    <= erro_d;
            done_q    <= done_d;
`ifdef ULA_OVERFLOW_EN
            ovf_q     <= ovf_d;
`endif
        end
    end

    assign resultado    = res_q;
    assign resultado_hi = res_hi_q;
    assign zero         = zero_q;
    assign condicao     = cond_q;
    assign erro         = erro_q;
    assign done         = done_q;
    assign busy         = (state_q != IDLE);
`ifdef ULA_OVERFLOW_EN
    assign overflow     = ovf_q;
`endif

endmodule

// File: tb/tb_ula_multiciclo.sv
// Randomized bench for ula_multiciclo: a countdown-based behavioural model is
// checked every cycle, plus directed cases with literal expectations.
module tb_ula_multiciclo;
    localparam int W = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [3:0]    sinal_controle;
    logic [W-1:0]  a, b;
    logic [4:0]    shamt;
    logic [W-1:0]  resultado, resultado_hi;
    logic          zero, condicao, erro, busy, done;
`ifdef ULA_OVERFLOW_EN
    logic          overflow;
`endif

    ula_multiciclo #(.WIDTH(W)) dut (
        .clock(clock), .reset(reset), .start(start), .sinal_controle(sinal_controle),
        .a(a), .b(b), .shamt(shamt), .resultado(resultado), .resultado_hi(resultado_hi),
        .zero(zero), .condicao(condicao), .erro(erro),
`ifdef ULA_OVERFLOW_EN
        .overflow(overflow),
`endif
        .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] hi;
        logic z, c, e, ov, multi;
    } res_t;

    function automatic res_t calc(input logic [3:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, input logic [4:0] s);
        res_t t;
        logic [63:0] p;
        longint sx, sy, sr;
        t = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sr = 0;
        case (op)
            4'd0: t.r = x & y;
            4'd1: t.r = x | y;
            4'd2: begin t.r = x + y; sr = sx + sy; end
            4'd3: begin t.r = x - y; sr = sx - sy; end
            4'd4: begin p = 64'(x) * 64'(y); t.r = p[31:0]; t.hi = p[63:32]; t.multi = 1'b1; end
            4'd5: begin
                if (y == 0) begin t.r = '1; t.hi = x; t.e = 1'b1; end
                else begin t.r = x / y; t.hi = x % y; t.multi = 1'b1; end
            end
            4'd6: t.r = y >> s;
            4'd7: t.r = y << s;
            4'd8: t.r = ~(x | y);
            4'd9:  begin t.r = x - y; t.c = (x == y); end
            4'd10: begin t.r = x - y; t.c = (sx < sy); end
            4'd11: begin t.r = x - y; t.c = (sx > sy); end
            4'd12: begin t.r = x - y; t.c = (x != y); end
            4'd13: t.r = x;
            default: t.e = 1'b1;
        endcase
        if (op == 4'd2 || op == 4'd3)
            t.ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        t.z = (t.r == 0);
        return t;
    endfunction

    // Model: a pending multi-cycle op completes after W clock edges; start is ignored meanwhile.
    res_t cur, m_out, m_pend;
    int   m_rem;
    logic m_done;
    always_comb cur = calc(sinal_controle, a, b, shamt);

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_out  <= '0;
            m_pend <= '0;
            m_rem  <= 0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_out  <= m_pend;
                    m_done <= 1'b1;
                end
            end else if (start) begin
                if (cur.multi) begin
                    m_pend <= cur;
                    m_rem  <= W;
                end else begin
                    m_out  <= cur;
                    m_done <= 1'b1;
                end
            end
        end
    end

    always @(negedge clock) begin
        check("busy", busy, (m_rem != 0));
        check("done", done, m_done);
        check("resultado", resultado, m_out.r);
        check("resultado_hi", resultado_hi, m_out.multi ? m_out.hi : (m_out.e && !m_out.r[0] ? '0 : m_out.hi));
        check("zero", zero, m_out.z);
        check("condicao", condicao, m_out.c);
        check("erro", erro, m_out.e);
`ifdef ULA_OVERFLOW_EN
        check("overflow", overflow, m_out.ov);
`endif
    end

    task automatic run(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [4:0] s, input bit noise, output int lat);
        @(negedge clock);
        sinal_controle = op; a = x; b = y; shamt = s; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        lat = 0;
        while (!done && lat < W + 4) begin
            if (noise && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                sinal_controle = 4'($urandom_range(0, 15));
                a = $urandom; b = $urandom; shamt = 5'($urandom);
            end else start = 1'b0;
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
        $display("txn op=%0d a=%h b=%h lat=%0d res=%h hi=%h", op, x, y, lat, resultado, resultado_hi);
        if (!done) check("done_timeout", 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        bit seen;
        logic [3:0] op;
        logic [W-1:0] x, y;
        reset = 1'b0; start = 1'b0; sinal_controle = '0; a = '0; b = '0; shamt = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_res", resultado, 0);

        run(4'd2, 32'd5, 32'd7, 5'd0, 0, lat);
        check("add_lat", lat, 0); check("add_res", resultado, 12); check("add_zero", zero, 0);
        run(4'd4, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, lat);
        check("mul_lat", lat, W); check("mul_lo", resultado, 32'hFFFF_FFFE); check("mul_hi", resultado_hi, 1);
        run(4'd5, 32'd100, 32'd7, 5'd0, 0, lat);
        check("div_lat", lat, W); check("div_q", resultado, 14); check("div_r", resultado_hi, 2);
        run(4'd5, 32'd100, 32'd0, 5'd0, 0, lat);
        check("dz_lat", lat, 0); check("dz_res", resultado, 32'hFFFF_FFFF);
        check("dz_hi", resultado_hi, 100); check("dz_erro", erro, 1);
        run(4'd10, -32'sd3, 32'd2, 5'd0, 0, lat); check("blt_cond", condicao, 1);
        run(4'd11, -32'sd3, 32'd2, 5'd0, 0, lat); check("bgt_cond", condicao, 0);
        run(4'd9, 32'd9, 32'd9, 5'd0, 0, lat);
        check("beq_cond", condicao, 1); check("beq_zero", zero, 1);
        run(4'd14, 32'd3, 32'd4, 5'd0, 0, lat);
        check("inv_erro", erro, 1); check("inv_res", resultado, 0);
        run(4'd6, 32'd0, 32'h8000_0000, 5'd31, 0, lat); check("srl_res", resultado, 1);
`ifdef ULA_OVERFLOW_EN
        run(4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 0, lat);
        check("ovf_res", resultado, 32'h8000_0000); check("ovf_flag", overflow, 1);
        run(4'd14, 32'd1, 32'd1, 5'd0, 0, lat);
        check("ovf_inv_erro", erro, 1); check("ovf_inv_res", resultado, 0); check("ovf_inv_flag", overflow, 0);
`endif

        // Back-to-back single-cycle starts
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            sinal_controle = 4'($urandom_range(0, 3));
            a = $urandom; b = $urandom; start = 1'b1;
            @(negedge clock);
        end
        start = 1'b0;

        // Re-pulse during mul is ignored; reset mid-op aborts without done
        @(negedge clock);
        sinal_controle = 4'd4; a = 32'd1234; b = 32'd5678; start = 1'b1;
        @(negedge clock); start = 1'b0;
        repeat (9) @(negedge clock);
        sinal_controle = 4'd2; a = 32'd1; b = 32'd1; start = 1'b1;
        @(negedge clock); start = 1'b0;
        check("repulse_busy", busy, 1);
        check("repulse_done", done, 0);
        repeat (9) @(negedge clock);
        reset = 1'b1;
        #1;
        check("rst_busy", busy, 0); check("rst_res", resultado, 0); check("rst_hi", resultado_hi, 0);
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check("rst_no_done", seen, 0);

        // Randomized transactions with ignored start noise while busy
        for (int i = 0; i < 120; i++) begin
            op = ($urandom_range(0, 3) == 0) ? 4'(4 + $urandom_range(0, 1)) : 4'($urandom_range(0, 15));
            x = $urandom;
            y = ($urandom_range(0, 7) == 0) ? '0 : ($urandom_range(0, 1) ? 32'($urandom_range(1, 300)) : $urandom);
            run(op, x, y, 5'($urandom), 1, lat);
        end
        repeat (3) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
